// File: rtl/ita_requant_pipe.sv
// ita_requant_pipe: elastic two-stage requantizer (acc * eps, rounded shift, offset, int8 saturation).
// Optional saturation counter port sat_count_o is built when ITA_REQUANT_SAT_CNT_EN is defined.
module ita_requant_pipe #(
   parameter int unsigned N_PE      = 16,
   parameter int unsigned ACC_WIDTH = 26,
   parameter int unsigned EMS       = 8,
   parameter int unsigned OUT_WIDTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [N_PE*ACC_WIDTH-1:0]     data_i,
   input  logic [EMS-1:0]                eps_mult_i,
   input  logic [EMS-1:0]                right_shift_i,
   input  logic [OUT_WIDTH-1:0]          add_i,
   input  logic                          clear_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [N_PE*OUT_WIDTH-1:0]     data_o
`ifdef ITA_REQUANT_SAT_CNT_EN
   ,
   output logic [15:0]                   sat_count_o
`endif
);

   localparam int unsigned PW  = ACC_WIDTH + EMS + 1;
   localparam int unsigned PW1 = PW + 1;
   localparam int unsigned PW2 = PW + 2;

   localparam logic signed [PW+1:0]  SAT_MAX = PW2'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [PW+1:0]  SAT_MIN = PW2'(-(2 ** (OUT_WIDTH - 1)));
   localparam logic [OUT_WIDTH-1:0]  OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]  OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

   // Rounded arithmetic shift of the product plus the signed offset, before saturation.
   function automatic logic signed [PW+1:0] rq_sum(input logic signed [PW-1:0] prod,
                                                   input logic [EMS-1:0] shift,
                                                   input logic [OUT_WIDTH-1:0] add);
      int unsigned          s;
      logic signed [PW:0]   rnd;
      logic signed [PW:0]   t;
      s   = (32'(shift) > PW) ? PW : 32'(shift);
      rnd = (s == 0) ? '0 : $signed(PW1'(1) << (s - 1));
      t   = $signed({prod[PW-1], prod}) + rnd;
      t   = t >>> s;
      return $signed({t[PW], t}) + $signed({{(PW2 - OUT_WIDTH){add[OUT_WIDTH-1]}}, add});
   endfunction

   // Clip a lane sum into the signed output range.
   function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [PW+1:0] v);
      if (v > SAT_MAX) return OUT_MAX;
      if (v < SAT_MIN) return OUT_MIN;
      return v[OUT_WIDTH-1:0];
   endfunction

   logic                   s1_valid;
   logic signed [PW-1:0]   s1_prod [N_PE];
   logic [EMS-1:0]         s1_shift;
   logic [OUT_WIDTH-1:0]   s1_add;

   logic                   s2_adv;
   logic                   s1_load;
   logic                   s2_load;

   logic signed [PW-1:0]   lane_prod [N_PE];
   logic signed [PW+1:0]   lane_sum  [N_PE];
   logic [N_PE*OUT_WIDTH-1:0] lane_out;

   assign s2_adv  = !valid_o || ready_i;
   assign ready_o = !s1_valid || s2_adv;
   assign s1_load = valid_i && ready_o && !clear_i;
   assign s2_load = s1_valid && s2_adv && !clear_i;

   // Per-lane multiply of the incoming beat and requantization of the stage-1 beat.
   always_comb begin
      lane_out = '0;
      for (int i = 0; i < int'(N_PE); i++) begin
         lane_prod[i] = PW'($signed(data_i[i*ACC_WIDTH +: ACC_WIDTH]))
                        * PW'($signed({1'b0, eps_mult_i}));
         lane_sum[i]  = rq_sum(s1_prod[i], s1_shift, s1_add);
         lane_out[i*OUT_WIDTH +: OUT_WIDTH] = sat(lane_sum[i]);
      end
   end

   // Stage valids: clear wins over accept and advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         valid_o  <= 1'b0;
      end else if (clear_i) begin
         s1_valid <= 1'b0;
         valid_o  <= 1'b0;
      end else begin
         if (ready_o) s1_valid <= valid_i;
         if (s2_adv)  valid_o  <= s1_valid;
      end
   end

   // Stage 1 data: products and the beat's own shift/offset constants.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(N_PE); i++) s1_prod[i] <= '0;
         s1_shift <= '0;
         s1_add   <= '0;
      end else if (s1_load) begin
         for (int i = 0; i < int'(N_PE); i++) s1_prod[i] <= lane_prod[i];
         s1_shift <= right_shift_i;
         s1_add   <= add_i;
      end
   end

   // Stage 2 data: registered int8 output lanes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      data_o <= '0;
      else if (s2_load) data_o <= lane_out;
   end

`ifdef ITA_REQUANT_SAT_CNT_EN
   localparam int unsigned CNT_W = $clog2(N_PE + 1);

   logic [CNT_W-1:0] clip_cnt;
   logic [CNT_W-1:0] s2_clip;
   logic [16:0]      sat_nxt;

   // Number of clipped lanes in the stage-1 beat.
   always_comb begin
      clip_cnt = '0;
      for (int i = 0; i < int'(N_PE); i++) begin
         if ((lane_sum[i] > SAT_MAX) || (lane_sum[i] < SAT_MIN))
            clip_cnt = clip_cnt + CNT_W'(1);
      end
      sat_nxt = 17'(sat_count_o) + 17'(s2_clip);
   end

   // Clip count travels with the output beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      s2_clip <= '0;
      else if (s2_load) s2_clip <= clip_cnt;
   end

   // Sticky-saturating counter of clipped lanes on completed output beats.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 sat_count_o <= '0;
      else if (clear_i)            sat_count_o <= '0;
      else if (valid_o && ready_i) sat_count_o <= sat_nxt[16] ? 16'hFFFF : sat_nxt[15:0];
   end
`endif

endmodule

// File: tb/tb_ita_requant_pipe.sv
// Self-checking bench for ita_requant_pipe: directed steps, expected beats queued on accept.
module tb_ita_requant_pipe;

   localparam int unsigned N_PE = 16;
   localparam int unsigned AW   = 26;
   localparam int unsigned OW   = 8;
   localparam int unsigned DW   = N_PE * AW;
   localparam int unsigned QW   = N_PE * OW;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           valid_i;
   logic           ready_o;
   logic [DW-1:0]  data_i;
   logic [7:0]     eps_mult_i;
   logic [7:0]     right_shift_i;
   logic [7:0]     add_i;
   logic           clear_i;
   logic           valid_o;
   logic           ready_i;
   logic [QW-1:0]  data_o;
`ifdef ITA_REQUANT_SAT_CNT_EN
   logic [15:0]    sat_count_o;
`endif

   int tests = 0;
   int fails = 0;
   logic [QW-1:0] exp_q[$];

   ita_requant_pipe dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .eps_mult_i(eps_mult_i), .right_shift_i(right_shift_i),
      .add_i(add_i), .clear_i(clear_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o)
`ifdef ITA_REQUANT_SAT_CNT_EN
      , .sat_count_o(sat_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] all_lanes(input int v);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < int'(N_PE); i++) d[i*AW +: AW] = 26'(v);
      return d;
   endfunction

   function automatic logic [QW-1:0] all_out(input int v);
      logic [QW-1:0] q;
      q = '0;
      for (int i = 0; i < int'(N_PE); i++) q[i*OW +: OW] = 8'(v);
      return q;
   endfunction

   // Lane i carries k*7+i; with eps=1, shift=0, add=0 the output equals the input.
   function automatic logic [DW-1:0] ramp(input int k);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < int'(N_PE); i++) d[i*AW +: AW] = 26'(k * 7 + i);
      return d;
   endfunction

   function automatic logic [QW-1:0] ramp_out(input int k);
      logic [QW-1:0] q;
      q = '0;
      for (int i = 0; i < int'(N_PE); i++) q[i*OW +: OW] = 8'(k * 7 + i);
      return q;
   endfunction

   // Present a beat from posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input logic [7:0] eps, input logic [7:0] sh,
                       input logic [7:0] add, input logic [QW-1:0] exp, input bit push);
      bit done;
      done          = 1'b0;
      valid_i       = 1'b1;
      data_i        = d;
      eps_mult_i    = eps;
      right_shift_i = sh;
      add_i         = add;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk_i);
         if (ready_o) begin
            if (push && !clear_i) exp_q.push_back(exp);
            done = 1'b1;
         end
         @(posedge clk_i);
         #1;
      end
      if (!done) begin
         tests++;
         fails++;
         $error("FAIL send_timeout: observed ready_o=0 for 40 cycles expected accept");
      end
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Scoreboard: compare every completed output beat against the oldest expected beat.
   always @(negedge clk_i) begin
      if (rst_ni && valid_o && ready_i) begin
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_beat: observed %0h expected no beat", data_o);
         end
         if (exp_q.size() != 0) begin
            logic [QW-1:0] e;
            e = exp_q.pop_front();
            check("beat_data", DW'(data_o), DW'(e));
         end
      end
   end

   initial begin
      logic [DW-1:0] d;
      logic [QW-1:0] q;

      rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; eps_mult_i = '0; right_shift_i = '0;
      add_i = '0; clear_i = 1'b0; ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_valid_o", DW'(valid_o), DW'(1'b0));
      check("rst_ready_o", DW'(ready_o), DW'(1'b1));
      check("rst_data_o",  DW'(data_o),  '0);
`ifdef ITA_REQUANT_SAT_CNT_EN
      check("rst_sat_cnt", DW'(sat_count_o), '0);
`endif
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic: 500*64 = 32000, (32000+128)>>8 = 125; valid_o two cycles after presenting.
      send(all_lanes(500), 8'd64, 8'd8, 8'd0, all_out(125), 1'b1);
      valid_i = 1'b0;
      @(negedge clk_i);
      check("lat_cycle1_valid", DW'(valid_o), DW'(1'b0));
      @(negedge clk_i);
      check("lat_cycle2_valid", DW'(valid_o), DW'(1'b1));
      @(posedge clk_i);
      #1;
      idle(2);

      // Rounding half toward +inf.
      d = '0;
      d[0*AW +: AW] = 26'(3);
      d[1*AW +: AW] = 26'(-3);
      d[2*AW +: AW] = 26'(5);
      q = '0;
      q[0*OW +: OW] = 8'(2);
      q[1*OW +: OW] = 8'(-1);
      q[2*OW +: OW] = 8'(3);
      send(d, 8'd1, 8'd1, 8'd0, q, 1'b1);
      send(all_lanes(7), 8'd2, 8'd0, 8'd0, all_out(14), 1'b1);
      idle(3);

      // Saturation and offset.
      send(all_lanes(100000), 8'd255, 8'd0, 8'd0, all_out(127), 1'b1);
      idle(3);
`ifdef ITA_REQUANT_SAT_CNT_EN
      check("sat_cnt_16", DW'(sat_count_o), DW'(16));
`endif
      send(all_lanes(-100000), 8'd255, 8'd0, 8'd0, all_out(-128), 1'b1);
      send(all_lanes(120), 8'd1, 8'd0, 8'd10, all_out(127), 1'b1);
      idle(3);

      // Shift clamp and constant isolation.
      send(all_lanes(-5), 8'd1, 8'd255, 8'd3, all_out(3), 1'b1);
      send(all_lanes(10), 8'd4, 8'd0, 8'd0, all_out(40), 1'b1);
      valid_i = 1'b0;
      eps_mult_i = 8'd100;
      add_i = 8'd50;
      idle(4);

      // Back-pressure: two beats held, ready_o low, then a gapless stream of six.
      ready_i = 1'b0;
      send(ramp(1), 8'd1, 8'd0, 8'd0, ramp_out(1), 1'b1);
      send(ramp(2), 8'd1, 8'd0, 8'd0, ramp_out(2), 1'b1);
      fork
         begin
            for (int k = 3; k <= 6; k++) send(ramp(k), 8'd1, 8'd0, 8'd0, ramp_out(k), 1'b1);
            valid_i = 1'b0;
         end
         begin
            repeat (3) begin
               @(negedge clk_i);
               check("bp_ready_low", DW'(ready_o), DW'(1'b0));
               check("bp_hold_data", DW'(data_o), DW'(ramp_out(1)));
            end
            @(posedge clk_i);
            #1;
            ready_i = 1'b1;
            repeat (6) begin
               @(negedge clk_i);
               check("stream_no_gap", DW'(valid_o), DW'(1'b1));
            end
         end
      join
      idle(4);
      check("bp_drained", DW'(exp_q.size()), '0);

      // Flush with two beats in flight.
      ready_i = 1'b0;
      send(ramp(8), 8'd1, 8'd0, 8'd0, '0, 1'b0);
      send(ramp(9), 8'd1, 8'd0, 8'd0, '0, 1'b0);
      valid_i = 1'b0;
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      check("clr_valid_o", DW'(valid_o), DW'(1'b0));
      check("clr_ready_o", DW'(ready_o), DW'(1'b1));
      ready_i = 1'b1;
      idle(4);
      // Beat presented together with clear is dropped.
      valid_i = 1'b1;
      data_i  = ramp(10);
      clear_i = 1'b1;
      @(negedge clk_i);
      check("clr_drop_ready", DW'(ready_o), DW'(1'b1));
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      idle(3);
      @(negedge clk_i);
      check("clr_drop_none", DW'(valid_o), DW'(1'b0));
      @(posedge clk_i);
      #1;

      // Asynchronous reset mid-stream.
      ready_i = 1'b0;
      send(ramp(11), 8'd1, 8'd0, 8'd0, '0, 1'b0);
      send(ramp(12), 8'd1, 8'd0, 8'd0, '0, 1'b0);
      valid_i = 1'b0;
      #2;
      check("prerst_valid", DW'(valid_o), DW'(1'b1));
      rst_ni = 1'b0;
      #1;
      check("async_rst_valid", DW'(valid_o), DW'(1'b0));
      check("async_rst_data",  DW'(data_o),  '0);
      #3;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("postrst_ready", DW'(ready_o), DW'(1'b1));
      check("postrst_valid", DW'(valid_o), DW'(1'b0));
      ready_i = 1'b1;

      // Recovery beat after reset.
      send(all_lanes(500), 8'd64, 8'd8, 8'd0, all_out(125), 1'b1);
      valid_i = 1'b0;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk_i);
      #1;
      check("final_drained", DW'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
